// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature step generator: FSM states,
// direction encoding and the phase-index to {A,B} mapping.
package quad_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // {A,B} for phase index 3..0, packed so index i sits at bits [2i+1:2i].
  // Index order 0..3 gives 00, 10, 11, 01: one channel toggles per step.
  localparam logic [7:0] PHASE_AB = 8'b01_11_10_00;

  function automatic logic [1:0] phase_to_ab(input logic [1:0] idx);
    return PHASE_AB[{idx, 1'b0} +: 2];
  endfunction

  // Next phase index; the 2-bit wrap gives mod-4 behaviour in both directions.
  function automatic logic [1:0] phase_step(input logic [1:0] idx, input logic dir);
    return (dir == DIR_FWD) ? (idx + 2'd1) : (idx - 2'd1);
  endfunction

endpackage

// File: rtl/quad_pb_pulser.sv
// Pushbutton one-shot: a request while the output is low produces a
// high pulse of exactly PB_CYCLES clocks; requests during the pulse are dropped.
module quad_pb_pulser #(
  parameter int PB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic pb
);

  localparam int TW = (PB_CYCLES > 1) ? $clog2(PB_CYCLES) : 1;

  logic [TW-1:0] timer;

  // Timer holds the number of high cycles still to follow the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pb    <= 1'b0;
      timer <= '0;
    end else if (!pb) begin
      if (req) begin
        pb    <= 1'b1;
        timer <= TW'(PB_CYCLES - 1);
      end
    end else if (timer == '0) begin
      pb <= 1'b0;
    end else begin
      timer <= timer - TW'(1);
    end
  end

endmodule

// File: rtl/quad_step_generator.sv
// Quadrature encoder emulator: turns step commands into A/B quadrature
// edges spaced by a programmable period, tracks a 4-bit modelled position,
// and drives a pushbutton pulse on request.
//
// Command handshake: a command transfers on a rising clock edge where
// cmd_valid and cmd_ready are both high; cmd_dir/cmd_steps/step_period are
// sampled only in that cycle. cmd_ready is high exactly when the step
// engine is idle (including the cycle a previous command signals done).
module quad_step_generator
  import quad_pkg::*;
#(
  parameter int DIV_W          = 16,
  parameter int CNT_W          = 8,
  parameter int EDGES_PER_STEP = 4,
  parameter int PB_CYCLES      = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] step_period,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             pb_req,
  output logic             A,
  output logic             B,
  output logic             PB,
  output logic             busy,
  output logic             done,
  output logic [3:0]       pos
);

  if (!(EDGES_PER_STEP == 1 || EDGES_PER_STEP == 2 || EDGES_PER_STEP == 4)) begin : g_bad_eps
    $error("EDGES_PER_STEP must be 1, 2 or 4");
  end
  if (PB_CYCLES < 1) begin : g_bad_pb
    $error("PB_CYCLES must be at least 1");
  end

  localparam int               REM_W    = CNT_W + 2;
  localparam logic [REM_W-1:0] EPS_MASK = REM_W'(EDGES_PER_STEP - 1);

  state_t             state;
  logic [1:0]         phase;
  logic               dir_q;
  logic [DIV_W-1:0]   per_q;
  logic [DIV_W-1:0]   div;
  logic [REM_W-1:0]   rem;
  logic [3:0]         pos_q;
  logic               a_q;
  logic               b_q;
  logic               done_q;

  logic [DIV_W-1:0]   period_eff;
  logic [REM_W-1:0]   total;
  logic               accept;
  logic               edge_fire;
  logic               edge_dir;
  logic [REM_W-1:0]   rem_src;
  logic [REM_W-1:0]   rem_dec;
  logic [1:0]         phase_nxt;
  logic               step_done;
  logic [3:0]         pos_nxt;

  assign period_eff = (step_period == '0) ? DIV_W'(1) : step_period;
  assign total      = REM_W'(cmd_steps) * REM_W'(EDGES_PER_STEP);
  assign accept     = (state == IDLE) && cmd_valid;

  // Decide whether an edge is registered this cycle. With a period of one
  // the first edge must be registered on the accepting clock itself so it
  // is visible one cycle after acceptance.
  always_comb begin
    edge_fire = 1'b0;
    edge_dir  = dir_q;
    rem_src   = rem;
    if (state == IDLE) begin
      if (accept && (cmd_steps != '0) && (period_eff == DIV_W'(1))) begin
        edge_fire = 1'b1;
        edge_dir  = cmd_dir;
        rem_src   = total;
      end
    end else if (div == DIV_W'(1)) begin
      edge_fire = 1'b1;
    end
    rem_dec   = rem_src - REM_W'(1);
    phase_nxt = phase_step(phase, edge_dir);
    step_done = (rem_dec & EPS_MASK) == '0;
    pos_nxt   = (edge_dir == DIR_FWD) ? (pos_q + 4'd1) : (pos_q - 4'd1);
  end

  // Step engine FSM with registered A/B, position and done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      phase  <= 2'd0;
      dir_q  <= DIR_FWD;
      per_q  <= DIV_W'(1);
      div    <= DIV_W'(1);
      rem    <= '0;
      pos_q  <= 4'd0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (edge_fire) begin
        phase      <= phase_nxt;
        {a_q, b_q} <= phase_to_ab(phase_nxt);
        if (step_done) begin
          pos_q <= pos_nxt;
        end
      end
      case (state)
        IDLE: begin
          if (accept) begin
            dir_q <= cmd_dir;
            per_q <= period_eff;
            if (cmd_steps == '0) begin
              done_q <= 1'b1;
            end else if (period_eff == DIV_W'(1)) begin
              div <= DIV_W'(1);
              rem <= rem_dec;
              if (rem_dec == '0) begin
                done_q <= 1'b1;
              end else begin
                state <= RUN;
              end
            end else begin
              div   <= period_eff - DIV_W'(1);
              rem   <= total;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (div == DIV_W'(1)) begin
            div <= per_q;
            rem <= rem_dec;
            if (rem_dec == '0) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end else begin
            div <= div - DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign done      = done_q;
  assign pos       = pos_q;
  assign A         = a_q;
  assign B         = b_q;

  quad_pb_pulser #(
    .PB_CYCLES(PB_CYCLES)
  ) u_pb (
    .clk(clk),
    .rst(rst),
    .req(pb_req),
    .pb (PB)
  );

endmodule

// File: tb/tb_quad_step_generator.sv
// Bench for quad_step_generator: directed scenarios followed by random
// traffic, checked every cycle against a timeline model of the generator.
module tb_quad_step_generator;

  localparam int DIV_W = 16;
  localparam int CNT_W = 8;
  localparam int EPS   = 4;
  localparam int PBC   = 10;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DIV_W-1:0] step_period = '0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_dir = 1'b1;
  logic [CNT_W-1:0] cmd_steps = '0;
  logic             pb_req = 1'b0;
  logic             A, B, PB, busy, done;
  logic [3:0]       pos;

  always #5 clk = ~clk;

  quad_step_generator #(
    .DIV_W(DIV_W), .CNT_W(CNT_W), .EDGES_PER_STEP(EPS), .PB_CYCLES(PBC)
  ) dut (
    .clk(clk), .rst(rst), .step_period(step_period), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
    .pb_req(pb_req), .A(A), .B(B), .PB(PB), .busy(busy), .done(done), .pos(pos)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [1:0] exp_q[$];

  // Timeline model: a command accepted in cycle m_acc produces edge k
  // (k = 1..m_n) visible in cycle m_acc + k*m_per.
  bit m_active = 0;
  int m_acc = 0, m_n = 0, m_per = 1, m_sgn = 1;
  int m_base_q = 0, m_base_pos = 0;
  int pb_from = 1, pb_until = 0;
  int ab_tbl[4] = '{0, 2, 3, 1};

  // Loopback decoder built from the observed A/B waveform.
  int dec_idx = 0, dec_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int m_edges(int c);
    int e;
    if (!m_active || c <= m_acc) return 0;
    e = (c - m_acc) / m_per;
    return (e > m_n) ? m_n : e;
  endfunction

  function automatic int m_qpos(int c);
    return m_base_q + m_sgn * m_edges(c);
  endfunction

  function automatic int m_ab(int c);
    return ab_tbl[((m_qpos(c) % 4) + 4) % 4];
  endfunction

  function automatic int m_pos(int c);
    return (((m_base_pos + m_sgn * (m_edges(c) / EPS)) % 16) + 16) % 16;
  endfunction

  function automatic bit m_done(int c);
    return m_active && (c == m_acc + ((m_n == 0) ? 1 : m_n * m_per));
  endfunction

  function automatic bit m_busy(int c);
    return m_active && (c > m_acc) && (c < m_acc + m_n * m_per);
  endfunction

  function automatic bit m_pb(int c);
    return (c >= pb_from) && (c <= pb_until);
  endfunction

  function automatic int ab_to_idx(logic [1:0] ab);
    case (ab)
      2'b00: return 0;
      2'b10: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_active = 0; m_base_q = 0; m_base_pos = 0;
    pb_from = 1; pb_until = 0;
    dec_idx = 0; dec_cnt = 0;
  endtask

  task automatic check_outputs();
    int idx_new, delta;
    chk("ab",        {A, B},    m_ab(cyc));
    chk("pos",       pos,       m_pos(cyc));
    chk("busy",      busy,      m_busy(cyc));
    chk("done",      done,      m_done(cyc));
    chk("cmd_ready", cmd_ready, !m_busy(cyc));
    chk("pb",        PB,        m_pb(cyc));
    idx_new = ab_to_idx({A, B});
    delta   = (idx_new - dec_idx + 4) % 4;
    chk("single_toggle", (delta == 2), 0);
    if (delta == 1) dec_cnt++;
    if (delta == 3) dec_cnt--;
    dec_idx = idx_new;
  endtask

  // ---------------- driver tasks ----------------
  // Apply the model's view of the current cycle's inputs, advance one
  // clock, then check the outputs of the new cycle.
  task automatic tick();
    if (!rst) begin
      if (cmd_valid && !m_busy(cyc)) begin
        int nq, np;
        nq = m_qpos(cyc);
        np = m_pos(cyc);
        m_base_q   = nq;
        m_base_pos = np;
        m_active   = 1;
        m_acc      = cyc;
        m_n        = int'(cmd_steps) * EPS;
        m_per      = (step_period == '0) ? 1 : int'(step_period);
        m_sgn      = cmd_dir ? 1 : -1;
      end
      if (pb_req && !m_pb(cyc)) begin
        pb_from  = cyc + 1;
        pb_until = cyc + PBC;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic offer_cmd(input logic dir, input int steps, input int period);
    cmd_valid   = 1'b1;
    cmd_dir     = dir;
    cmd_steps   = CNT_W'(steps);
    step_period = DIV_W'(period);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    pb_req = 1'b0;
    #1;
    model_reset();
    chk("rst_ab",    {A, B},    0);
    chk("rst_busy",  busy,      0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done",  done,      0);
    chk("rst_pos",   pos,       0);
    chk("rst_pb",    PB,        0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int guard = 0;
    while (done !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int t0, guard;

    // Reset state
    tick();
    tick();
    chk("reset_ab", {A, B}, 0);
    chk("reset_ready", cmd_ready, 1);
    chk("reset_pos", pos, 0);
    rst = 1'b0;
    tick();

    // Forward, 1 step, period 3: edges at +3,+6,+9,+12
    offer_cmd(1'b1, 1, 3);
    t0 = cyc;
    tick();
    cmd_valid = 1'b0;
    exp_q.push_back(2'b10); exp_q.push_back(2'b11);
    exp_q.push_back(2'b01); exp_q.push_back(2'b00);
    for (int k = 1; k <= 4; k++) begin
      while (cyc < t0 + 3 * k) tick();
      chk("fwd1_edge", {A, B}, exp_q.pop_front());
    end
    chk("fwd1_done", done, 1);
    chk("fwd1_pos", pos, 1);
    chk("fwd1_ready", cmd_ready, 1);
    tick();

    // Reverse, 2 steps, period 0 from pos 0: an edge every cycle
    do_reset();
    tick();
    offer_cmd(1'b0, 2, 0);
    t0 = cyc;
    tick();
    cmd_valid = 1'b0;
    exp_q.push_back(2'b01); exp_q.push_back(2'b11);
    exp_q.push_back(2'b10); exp_q.push_back(2'b00);
    for (int k = 1; k <= 4; k++) begin
      while (cyc < t0 + k) tick();
      chk("rev2_edge", {A, B}, exp_q.pop_front());
    end
    while (cyc < t0 + 8) tick();
    chk("rev2_done", done, 1);
    chk("rev2_pos", pos, 14);
    chk("rev2_edges", dec_cnt, -8);
    tick();

    // steps=0 held: done every cycle, nothing moves
    offer_cmd(1'b1, 0, $urandom_range(0, 5));
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("zero_done", done, 1);
      chk("zero_ab", {A, B}, 0);
      chk("zero_pos", pos, 14);
    end
    cmd_valid = 1'b0;
    tick();
    tick();

    // Back-to-back: fwd 3 then rev 3 offered in the done cycle
    offer_cmd(1'b1, 3, 2);
    tick();
    cmd_valid = 1'b0;
    wait_done("b2b_first_done");
    chk("b2b_mid_pos", pos, 1);
    offer_cmd(1'b0, 3, 1);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_second_edge", {A, B}, 2'b01);
    chk("b2b_second_busy", busy, 1);
    wait_done("b2b_second_done");
    chk("b2b_final_pos", pos, 14);
    chk("b2b_final_ab", {A, B}, 0);
    tick();

    // Pushbutton: requests at t and t+5 give one pulse in cycles 1..10
    pb_req = 1'b1;
    t0 = cyc;
    tick();
    pb_req = 1'b0;
    chk("pb_rise", PB, 1);
    while (cyc < t0 + 5) tick();
    pb_req = 1'b1;
    tick();
    pb_req = 1'b0;
    while (cyc < t0 + 10) tick();
    chk("pb_last_high", PB, 1);
    tick();
    chk("pb_fall", PB, 0);
    repeat (3) tick();

    // Held request re-triggers after one low cycle
    pb_req = 1'b1;
    repeat (25) tick();
    pb_req = 1'b0;
    repeat (12) tick();

    // Reset mid-command
    offer_cmd(1'b1, 5, 4);
    tick();
    cmd_valid = 1'b0;
    repeat (7) tick();
    chk("midrst_busy_before", busy, 1);
    do_reset();
    repeat (30) tick();

    // Random traffic, including period changes while running
    for (int i = 0; i < 1500; i++) begin
      cmd_valid   = ($urandom_range(0, 3) == 0);
      cmd_dir     = 1'($urandom_range(0, 1));
      cmd_steps   = CNT_W'($urandom_range(0, 5));
      step_period = DIV_W'($urandom_range(0, 3));
      pb_req      = ($urandom_range(0, 15) == 0);
      tick();
    end
    cmd_valid = 1'b0;
    pb_req    = 1'b0;
    guard = 0;
    while (busy !== 1'b0 && guard < 200) begin
      tick();
      guard++;
    end
    chk("rand_idle", busy, 0);
    tick();
    chk("loopback_vs_pos", (dec_cnt >>> 2) & 15, pos);
    chk("loopback_vs_model", (dec_cnt >>> 2) & 15, m_pos(cyc));

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_step_generator.md
Name: quad_step_generator

Overview:
Quadrature encoder emulator. It is the transmit side of the rotary-encoder interface: it turns step commands into A/B quadrature waveforms and turns press requests into pushbutton pulses. It drives the A/B/PB inputs of the rotary-encoder decoder for self-test and loopback, or an off-chip pin for external test. It keeps a 4-bit modelled position so the result can be compared against the decoder's encoder counter.

Parameters:
DIV_W, 16, width of the edge-interval divider.
CNT_W, 8, width of the step count per command.
EDGES_PER_STEP, 4, quadrature edges per step; legal values 1, 2, 4 (elaboration error otherwise).
PB_CYCLES, 1000, PB high time in clk cycles; must be >= 1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
step_period  in  DIV_W  clk cycles between successive quadrature edges; 0 is treated as 1
cmd_valid  in  1  step command valid
cmd_ready  out  1  generator can accept a command
cmd_dir  in  1  1 = forward (A leads B), 0 = reverse
cmd_steps  in  CNT_W  number of steps to emit
pb_req  in  1  request one pushbutton press
A  out  1  quadrature channel A
B  out  1  quadrature channel B
PB  out  1  pushbutton, active-high
busy  out  1  step engine in RUN
done  out  1  one-cycle pulse when a command completes
pos  out  4  modelled position, modulo 16

Behaviour:
- Reset (async assert, sync release):
  - A=0, B=0, PB=0, busy=0, done=0, pos=0, cmd_ready=1.
  - Phase index = 0; FSM in IDLE; PB timer cleared.
- Phase encoding, {A,B} by index 0..3: 00, 10, 11, 01.
  - Forward: index+1 mod 4.
  - Reverse: index-1 mod 4.
  - Exactly one of A/B toggles per edge. A and B are registered, glitch-free outputs.
- FSM states: IDLE and RUN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch dir, steps, and max(step_period,1).
  - cmd_steps==0: stay in IDLE; done=1 in the next cycle; no edges emitted.
  - Otherwise: go to RUN next cycle. Edges remaining = steps*EDGES_PER_STEP, computed at width CNT_W+2. Divider loads the latched period.
- RUN:
  - cmd_ready=0, busy=1. cmd_valid is ignored.
  - Divider counts down each cycle. When it expires: advance the phase one edge and reload the divider.
  - The first edge appears P cycles after the acceptance cycle (P = latched period). Edge spacing is exactly P cycles. Total command duration is N*EDGES_PER_STEP*P cycles.
  - Every EDGES_PER_STEP edges, pos updates by +1 (forward) or -1 (reverse), wrapping 15<->0.
  - On the final edge: done=1 in the cycle the final edge is visible on A/B; FSM returns to IDLE in that cycle, so cmd_ready=1.
  - A new command may be accepted in the cycle done is high (back-to-back).
- Phase persists across commands and is not reset to 0 between commands. Direction reversal between commands is therefore glitch-free.
- step_period changes while in RUN have no effect.
- PB engine, independent of the step FSM:
  - pb_req while PB=0: PB=1 from the next cycle for exactly PB_CYCLES cycles, then 0.
  - pb_req while PB=1 is ignored (not queued).
  - pb_req held continuously: PB=1 for PB_CYCLES cycles, then 0 for 1 cycle, then re-triggers.
- Simultaneous events:
  - Command acceptance and pb_req in the same cycle are both honoured.
  - A step edge and a PB edge may coincide.
- Reset mid-command: A/B drop to 00 immediately; the command is lost; no done pulse.

Decomposition:
- Shared package quad_pkg:
  - Phase-to-{A,B} lookup constant.
  - FSM state enum (IDLE, RUN).
  - Direction constants (DIR_FWD=1, DIR_REV=0).
- One natural sub-module: quad_pb_pulser, the PB_CYCLES one-shot with its timer.
- The step engine remains in the top block.

Test Plan:
- Reset release, then forward command with steps=1, period=3, EDGES_PER_STEP=4 -> {A,B} = 10, 11, 01, 00 at cycles 3, 6, 9, 12 after acceptance; done pulses with the 00 edge; pos=1; cmd_ready returns high.
- Reverse command with steps=2, period=0, starting from pos=0 -> edges every cycle; {A,B} = 01, 11, 10, 00, ...; pos=14 (wrap); 8 edges total.
- cmd_valid held high with steps=0 -> done every cycle; A/B unchanged; pos unchanged.
- Back-to-back commands (fwd 3, then rev 3, second one offered during done) -> second accepted in the done cycle; no gap edge lost; final pos equals starting pos; no double toggle of A/B.
- pb_req pulses at t=0 and t=5 with PB_CYCLES=10 -> PB high for cycles 1..10 only; second request ignored.
- Assert rst mid-RUN -> A=B=0, busy=0, cmd_ready=1, no done pulse; loopback into the decoder reports a count matching pos across random commands.
